// File: rtl/ct_spsram_pkg.sv
// Shared types and sizing helpers for the parametrised single-port SRAM.
package ct_spsram_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } init_state_e;

    // Number of write-enable lanes for a given word width and lane size.
    function automatic int unsigned we_width(int unsigned data_width, int unsigned we_gran);
        return data_width / we_gran;
    endfunction

    // Index / sweep-counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ct_spsram_init_ctrl.sv
// Clear engine: sweeps INIT_VAL over the array after reset or on request and
// owns the array port (override outputs) while BUSY is high.
module ct_spsram_init_ctrl
    import ct_spsram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DEPTH      = 1024,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_req,
    output logic                  busy,
    output logic                  ovr_en_c,
    output logic [ADDR_WIDTH-1:0] ovr_addr_c,
    output logic [DATA_WIDTH-1:0] ovr_data_c
);

    localparam int unsigned      CNT_W    = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    init_state_e      state_q;
    init_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
        end
    end

    // A request still high on the final sweep write chains straight into a new sweep.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovr_en_c = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                ovr_en_c = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (!init_req) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (init_req) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
        endcase
        busy_d = (state_d == ST_INIT);
    end

    assign ovr_addr_c = ADDR_WIDTH'(cnt_q);
    assign ovr_data_c = INIT_VAL;

endmodule

// File: rtl/ct_spsram_param_init.sv
// Parametrised single-port SRAM with per-lane write mask, optional second
// output register and a hardware clear engine.
module ct_spsram_param_init
    import ct_spsram_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DEPTH      = 1024,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           WE_GRAN    = 1,
    parameter int unsigned           OUT_REG    = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                                         CLK,
    input  logic                                         cpurst_b,
    input  logic [ADDR_WIDTH-1:0]                        A,
    input  logic                                         CEN,
    input  logic                                         GWEN,
    input  logic [we_width(DATA_WIDTH, WE_GRAN)-1:0]     WEN,
    input  logic [DATA_WIDTH-1:0]                        D,
    output logic [DATA_WIDTH-1:0]                        Q,
    input  logic                                         INIT_REQ,
    output logic                                         BUSY
);

    localparam int unsigned           WE_W      = we_width(DATA_WIDTH, WE_GRAN);
    localparam int unsigned           IDX_W     = cnt_width(DEPTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

    if (DEPTH > (32'd1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("ct_spsram_param_init: DEPTH exceeds 2**ADDR_WIDTH");
    end
    if ((DATA_WIDTH % WE_GRAN) != 0) begin : g_bad_gran
        $error("ct_spsram_param_init: DATA_WIDTH not a multiple of WE_GRAN");
    end

    logic                  ovr_en_c;
    logic [ADDR_WIDTH-1:0] ovr_addr_c;
    logic [DATA_WIDTH-1:0] ovr_data_c;

    logic [DATA_WIDTH-1:0] lane_mask_c;
    logic                  in_range_c;
    logic                  user_wr_c;
    logic                  user_rd_c;

    logic                  wr_en_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;
    logic [DATA_WIDTH-1:0] wr_data_c;
    logic [DATA_WIDTH-1:0] wr_mask_c;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    ct_spsram_init_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_VAL   (INIT_VAL)
    ) u_init_ctrl (
        .clk        (CLK),
        .rst_n      (cpurst_b),
        .init_req   (INIT_REQ),
        .busy       (BUSY),
        .ovr_en_c   (ovr_en_c),
        .ovr_addr_c (ovr_addr_c),
        .ovr_data_c (ovr_data_c)
    );

    // Active-low lane enables expanded to a per-bit write mask.
    for (genvar i = 0; i < WE_W; i++) begin : g_lane
        assign lane_mask_c[i*WE_GRAN +: WE_GRAN] = {WE_GRAN{~WEN[i]}};
    end

    assign in_range_c = {1'b0, A} < DEPTH_LIM;
    assign user_wr_c  = !ovr_en_c && !CEN && !GWEN && in_range_c;
    assign user_rd_c  = !ovr_en_c && !CEN &&  GWEN;

    // Clear engine takes the port outright; user traffic is dropped, not queued.
    always_comb begin
        wr_en_c   = user_wr_c;
        wr_addr_c = A;
        wr_data_c = D;
        wr_mask_c = lane_mask_c;
        if (ovr_en_c) begin
            wr_en_c   = 1'b1;
            wr_addr_c = ovr_addr_c;
            wr_data_c = ovr_data_c;
            wr_mask_c = '1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en_c) begin
            mem[IDX_W'(wr_addr_c)] <= (mem[IDX_W'(wr_addr_c)] & ~wr_mask_c)
                                    | (wr_data_c & wr_mask_c);
        end
    end

    // First read stage: loads only on a granted read, out-of-range reads yield zero.
    always_ff @(posedge CLK or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_q <= '0;
        end else if (user_rd_c) begin
            rd_q <= in_range_c ? mem[IDX_W'(A)] : '0;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] pipe_q;

        always_ff @(posedge CLK or negedge cpurst_b) begin
            if (!cpurst_b) begin
                pipe_q <= '0;
            end else begin
                pipe_q <= rd_q;
            end
        end

        assign Q = pipe_q;
    end else begin : g_no_out_reg
        assign Q = rd_q;
    end

endmodule

// File: tb/tb_ct_spsram_param_init.sv
// Directed bench for ct_spsram_param_init: three instances share stimulus
// (DEPTH 16 latency 1, DEPTH 16 latency 2, DEPTH 12 with 4 address bits).
module tb_ct_spsram_param_init;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a_in;
    logic        cen;
    logic        gwen;
    logic [3:0]  wen;
    logic [31:0] d_in;
    logic        init_req;
    logic [31:0] q_a, q_b, q_c;
    logic        busy_a, busy_b, busy_c;

    int n_cmp;
    int n_err;

    ct_spsram_param_init #(
        .ADDR_WIDTH(5), .DEPTH(16), .DATA_WIDTH(32), .WE_GRAN(8), .OUT_REG(0), .INIT_VAL(IV)
    ) dut_a (
        .CLK(clk), .cpurst_b(rst_n), .A(a_in), .CEN(cen), .GWEN(gwen), .WEN(wen),
        .D(d_in), .Q(q_a), .INIT_REQ(init_req), .BUSY(busy_a)
    );

    ct_spsram_param_init #(
        .ADDR_WIDTH(5), .DEPTH(16), .DATA_WIDTH(32), .WE_GRAN(8), .OUT_REG(1), .INIT_VAL(IV)
    ) dut_b (
        .CLK(clk), .cpurst_b(rst_n), .A(a_in), .CEN(cen), .GWEN(gwen), .WEN(wen),
        .D(d_in), .Q(q_b), .INIT_REQ(init_req), .BUSY(busy_b)
    );

    ct_spsram_param_init #(
        .ADDR_WIDTH(4), .DEPTH(12), .DATA_WIDTH(32), .WE_GRAN(8), .OUT_REG(0), .INIT_VAL(IV)
    ) dut_c (
        .CLK(clk), .cpurst_b(rst_n), .A(a_in[3:0]), .CEN(cen), .GWEN(gwen), .WEN(wen),
        .D(d_in), .Q(q_c), .INIT_REQ(init_req), .BUSY(busy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int fall_a, fall_b, fall_c;
        repeat (2) tick;
        n_cmp++; if (q_a !== 32'h0) begin n_err++; $display("FAIL reset_q_a: got %h expected %h", q_a, 32'h0); end
        n_cmp++; if (q_b !== 32'h0) begin n_err++; $display("FAIL reset_q_b: got %h expected %h", q_b, 32'h0); end
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL reset_busy_a: got %b expected 1", busy_a); end
        rst_n  = 1'b1;
        fall_a = 0; fall_b = 0; fall_c = 0;
        for (int i = 1; i <= 24; i++) begin
            tick;
            if (!busy_a && fall_a == 0) fall_a = i;
            if (!busy_b && fall_b == 0) fall_b = i;
            if (!busy_c && fall_c == 0) fall_c = i;
        end
        n_cmp++; if (fall_a != 16) begin n_err++; $display("FAIL sweep_len_a: got %0d expected 16", fall_a); end
        n_cmp++; if (fall_b != 16) begin n_err++; $display("FAIL sweep_len_b: got %0d expected 16", fall_b); end
        n_cmp++; if (fall_c != 12) begin n_err++; $display("FAIL sweep_len_c: got %0d expected 12", fall_c); end
    endtask

    task automatic test_read_all;
        logic [31:0] exp_c, exp_b;
        for (int i = 0; i < 16; i++) begin
            a_in = 5'(i); cen = 1'b0; gwen = 1'b1;
            tick;
            exp_c = (i < 12) ? IV : 32'h0;
            exp_b = (i == 0) ? 32'h0 : IV;
            n_cmp++; if (q_a !== IV) begin n_err++; $display("FAIL read_all_a[%0d]: got %h expected %h", i, q_a, IV); end
            n_cmp++; if (q_c !== exp_c) begin n_err++; $display("FAIL read_all_c[%0d]: got %h expected %h", i, q_c, exp_c); end
            n_cmp++; if (q_b !== exp_b) begin n_err++; $display("FAIL read_all_b[%0d]: got %h expected %h", i, q_b, exp_b); end
        end
        cen = 1'b1;
        tick;
    endtask

    task automatic test_lane_write;
        a_in = 5'd5; d_in = 32'h11223344; wen = 4'b1010; cen = 1'b0; gwen = 1'b0;
        tick;
        n_cmp++; if (q_a !== IV) begin n_err++; $display("FAIL lane_wr_hold_a: got %h expected %h", q_a, IV); end
        n_cmp++; if (q_c !== 32'h0) begin n_err++; $display("FAIL lane_wr_hold_c: got %h expected %h", q_c, 32'h0); end
        gwen = 1'b1; wen = 4'hF;
        tick;
        n_cmp++; if (q_a !== 32'hA522A544) begin n_err++; $display("FAIL lane_rd_a: got %h expected %h", q_a, 32'hA522A544); end
        n_cmp++; if (q_c !== 32'hA522A544) begin n_err++; $display("FAIL lane_rd_c: got %h expected %h", q_c, 32'hA522A544); end
        cen = 1'b1;
        tick;
        n_cmp++; if (q_b !== 32'hA522A544) begin n_err++; $display("FAIL lane_rd_b: got %h expected %h", q_b, 32'hA522A544); end
    endtask

    task automatic test_out_reg;
        for (int i = 1; i <= 3; i++) begin
            a_in = 5'(i); d_in = 32'(i); wen = 4'h0; cen = 1'b0; gwen = 1'b0;
            tick;
        end
        wen = 4'hF; gwen = 1'b1;
        a_in = 5'd1; tick;
        n_cmp++; if (q_a !== 32'd1) begin n_err++; $display("FAIL b2b_a1: got %h expected %h", q_a, 32'd1); end
        n_cmp++; if (q_b !== 32'hA522A544) begin n_err++; $display("FAIL b2b_b_c1: got %h expected %h", q_b, 32'hA522A544); end
        a_in = 5'd2; tick;
        n_cmp++; if (q_b !== 32'd1) begin n_err++; $display("FAIL b2b_b_c2: got %h expected %h", q_b, 32'd1); end
        a_in = 5'd3; tick;
        n_cmp++; if (q_b !== 32'd2) begin n_err++; $display("FAIL b2b_b_c3: got %h expected %h", q_b, 32'd2); end
        cen = 1'b1; tick;
        n_cmp++; if (q_b !== 32'd3) begin n_err++; $display("FAIL b2b_b_c4: got %h expected %h", q_b, 32'd3); end
        tick;
        n_cmp++; if (q_b !== 32'd3) begin n_err++; $display("FAIL b2b_b_hold: got %h expected %h", q_b, 32'd3); end
        n_cmp++; if (q_a !== 32'd3) begin n_err++; $display("FAIL b2b_a_hold: got %h expected %h", q_a, 32'd3); end
        a_in = 5'd1; cen = 1'b0; tick;
        cen = 1'b1;
        n_cmp++; if (q_b !== 32'd3) begin n_err++; $display("FAIL gap_b_c1: got %h expected %h", q_b, 32'd3); end
        tick;
        n_cmp++; if (q_b !== 32'd1) begin n_err++; $display("FAIL gap_b_c2: got %h expected %h", q_b, 32'd1); end
        tick;
        n_cmp++; if (q_b !== 32'd1) begin n_err++; $display("FAIL gap_b_hold: got %h expected %h", q_b, 32'd1); end
        n_cmp++; if (q_a !== 32'd1) begin n_err++; $display("FAIL gap_a_hold: got %h expected %h", q_a, 32'd1); end
    endtask

    task automatic test_init_req;
        int n;
        a_in = 5'd7; d_in = 32'hDEADBEEF; wen = 4'h0; cen = 1'b0; gwen = 1'b0;
        tick;
        gwen = 1'b1; wen = 4'hF;
        tick;
        n_cmp++; if (q_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL pre_clear_a7: got %h expected %h", q_a, 32'hDEADBEEF); end
        cen = 1'b1; init_req = 1'b1;
        tick;
        init_req = 1'b0;
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL req_busy_rise: got %b expected 1", busy_a); end
        a_in = 5'd7; d_in = 32'h12345678; wen = 4'h0; cen = 1'b0; gwen = 1'b0;
        n = 0;
        while (busy_a && n < 40) begin
            tick;
            n++;
        end
        cen = 1'b1; gwen = 1'b1; wen = 4'hF;
        n_cmp++; if (n != 16) begin n_err++; $display("FAIL req_sweep_len: got %0d expected 16", n); end
        n_cmp++; if (q_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL sweep_q_hold: got %h expected %h", q_a, 32'hDEADBEEF); end
        a_in = 5'd7; cen = 1'b0; tick;
        cen = 1'b1;
        n_cmp++; if (q_a !== IV) begin n_err++; $display("FAIL cleared_a7: got %h expected %h", q_a, IV); end
        n_cmp++; if (q_c !== 32'h12345678) begin n_err++; $display("FAIL post_busy_wr_c7: got %h expected %h", q_c, 32'h12345678); end
    endtask

    task automatic test_init_hold;
        int n_low, n;
        init_req = 1'b1;
        n_low = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (!busy_a) n_low++;
        end
        init_req = 1'b0;
        n_cmp++; if (n_low != 0) begin n_err++; $display("FAIL hold_busy_low: got %0d expected 0", n_low); end
        n = 0;
        while (busy_a && n < 40) begin
            tick;
            n++;
        end
        n_cmp++; if (n != 9) begin n_err++; $display("FAIL hold_tail_len: got %0d expected 9", n); end
    endtask

    task automatic test_reset_mid;
        int n;
        a_in = 5'd3; cen = 1'b0; gwen = 1'b1; tick;
        cen = 1'b1;
        n_cmp++; if (q_a !== IV) begin n_err++; $display("FAIL pre_rst_q: got %h expected %h", q_a, IV); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (q_a !== 32'h0) begin n_err++; $display("FAIL async_rst_q_a: got %h expected %h", q_a, 32'h0); end
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL async_rst_busy: got %b expected 1", busy_a); end
        tick;
        rst_n = 1'b1;
        repeat (9) tick;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 1", busy_a); end
        n_cmp++; if (q_b !== 32'h0) begin n_err++; $display("FAIL mid_rst_q_b: got %h expected %h", q_b, 32'h0); end
        tick;
        rst_n = 1'b1;
        n = 0;
        while (busy_a && n < 40) begin
            tick;
            n++;
        end
        n_cmp++; if (n != 16) begin n_err++; $display("FAIL mid_rst_sweep_len: got %0d expected 16", n); end
    endtask

    task automatic test_out_of_range;
        a_in = 5'd13; d_in = 32'hDEADBEEF; wen = 4'h0; cen = 1'b0; gwen = 1'b0;
        tick;
        gwen = 1'b1; wen = 4'hF;
        tick;
        n_cmp++; if (q_c !== 32'h0) begin n_err++; $display("FAIL oor_rd_c13: got %h expected %h", q_c, 32'h0); end
        n_cmp++; if (q_a !== 32'hDEADBEEF) begin n_err++; $display("FAIL inrange_rd_a13: got %h expected %h", q_a, 32'hDEADBEEF); end
        a_in = 5'd1; tick;
        n_cmp++; if (q_c !== IV) begin n_err++; $display("FAIL alias_c1: got %h expected %h", q_c, IV); end
        a_in = 5'd31; tick;
        n_cmp++; if (q_a !== 32'h0) begin n_err++; $display("FAIL oor_rd_a31: got %h expected %h", q_a, 32'h0); end
        n_cmp++; if (q_c !== 32'h0) begin n_err++; $display("FAIL oor_rd_c15: got %h expected %h", q_c, 32'h0); end
        cen = 1'b1;
        tick;
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        a_in     = '0;
        cen      = 1'b1;
        gwen     = 1'b1;
        wen      = 4'hF;
        d_in     = '0;
        init_req = 1'b0;
        test_reset;
        test_read_all;
        test_lane_write;
        test_out_reg;
        test_init_req;
        test_init_hold;
        test_reset_mid;
        test_out_of_range;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
